// File: rtl/johnson_pkg.sv
// Shared constants and FSM state type for the Johnson code decoder.
package johnson_pkg;

  localparam int unsigned JOHNSON_W = 8;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [1:0] {
    StHunt,
    StCheck,
    StLocked
  } fsm_state_e;

endpackage

// File: rtl/johnson_code_chk.sv
// Combinational decode of an 8-bit Johnson code into a state index plus a legality flag.
module johnson_code_chk
  import johnson_pkg::*;
(
  input  logic [0:JOHNSON_W-1] code_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 legal_o
);

  logic [IDX_W:0] pcnt;
  logic [IDX_W:0] neg_pcnt;
  logic           ordered;

  always_comb begin
    pcnt    = '0;
    ordered = 1'b1;
    for (int i = 0; i < JOHNSON_W; i++) begin
      pcnt = pcnt + (IDX_W + 1)'(code_i[i]);
    end
    // Only one run boundary is allowed, and the run touching bit 7 must be the tail.
    for (int i = 0; i < JOHNSON_W - 1; i++) begin
      if ((code_i[i] != code_i[i+1]) && (code_i[i+1] != code_i[JOHNSON_W-1])) begin
        ordered = 1'b0;
      end
    end
    neg_pcnt = {1'b1, {IDX_W{1'b0}}} - pcnt;

    legal_o = ordered;
    if (!ordered) begin
      idx_o = '0;
    end else if (!code_i[JOHNSON_W-1]) begin
      idx_o = pcnt[IDX_W-1:0];
    end else begin
      idx_o = neg_pcnt[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code decoder with sequence-lock FSM and saturating sequence-error counter.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 en,
  input  logic [0:JOHNSON_W-1] code_in,
  input  logic                 clr_err,
  output logic [IDX_W-1:0]     idx,
  output logic                 idx_vld,
  output logic                 legal,
  output logic                 locked,
  output logic                 seq_err,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam logic [3:0] LockCntW = 4'(LOCK_CNT);

  logic [IDX_W-1:0] dec_idx;
  logic             dec_legal;

  johnson_code_chk u_code_chk (
    .code_i  (code_in),
    .idx_o   (dec_idx),
    .legal_o (dec_legal)
  );

  fsm_state_e       state_q, state_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             legal_q, legal_d;
  logic             vld_q, vld_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             in_seq;
  logic [3:0]       gcnt_inc;

  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    idx_d     = idx_q;
    legal_d   = legal_q;
    vld_d     = 1'b0;
    seq_err_d = 1'b0;
    // idx_q doubles as the previous index; 15 -> 0 wraps naturally.
    in_seq    = dec_legal && (dec_idx == (idx_q + IDX_W'(1)));
    gcnt_inc  = gcnt_q + 4'd1;

    if (en) begin
      idx_d   = dec_idx;
      legal_d = dec_legal;
      vld_d   = 1'b1;
      unique case (state_q)
        StHunt: begin
          if (dec_legal) begin
            gcnt_d  = 4'd1;
            state_d = (LOCK_CNT <= 1) ? StLocked : StCheck;
          end
        end
        StCheck: begin
          if (in_seq) begin
            gcnt_d = gcnt_inc;
            if (gcnt_inc >= LockCntW) begin
              state_d = StLocked;
            end
          end else if (dec_legal) begin
            gcnt_d = 4'd1;
          end else begin
            gcnt_d  = 4'd0;
            state_d = StHunt;
          end
        end
        StLocked: begin
          if (!in_seq) begin
            seq_err_d = 1'b1;
            if (dec_legal) begin
              gcnt_d  = 4'd1;
              state_d = StCheck;
            end else begin
              gcnt_d  = 4'd0;
              state_d = StHunt;
            end
          end
        end
        default: begin
          gcnt_d  = 4'd0;
          state_d = StHunt;
        end
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = '0;
    end else if (seq_err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q   <= StHunt;
      gcnt_q    <= 4'd0;
      idx_q     <= '0;
      legal_q   <= 1'b0;
      vld_q     <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gcnt_q    <= gcnt_d;
      idx_q     <= idx_d;
      legal_q   <= legal_d;
      vld_q     <= vld_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign idx     = idx_q;
  assign idx_vld = vld_q;
  assign legal   = legal_q;
  assign locked  = (state_q == StLocked);
  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed self-checking bench for johnson_decoder (default, ERR_W=2 and LOCK_CNT=1 instances).
module tb_johnson_decoder;

  logic       clk;
  logic       r;
  logic       en;
  logic [0:7] code_in;
  logic       clr_err;

  logic [3:0] idx, idx_e2, idx_l1;
  logic       idx_vld, vld_e2, vld_l1;
  logic       legal, legal_e2, legal_l1;
  logic       locked, locked_e2, locked_l1;
  logic       seq_err, seq_err_e2, seq_err_l1;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_e2;
  logic [7:0] err_cnt_l1;

  int unsigned n_total;
  int unsigned n_pass;

  johnson_decoder u_dut (
    .clk     (clk),
    .r       (r),
    .en      (en),
    .code_in (code_in),
    .clr_err (clr_err),
    .idx     (idx),
    .idx_vld (idx_vld),
    .legal   (legal),
    .locked  (locked),
    .seq_err (seq_err),
    .err_cnt (err_cnt)
  );

  johnson_decoder #(.LOCK_CNT(2), .ERR_W(2)) u_dut_e2 (
    .clk     (clk),
    .r       (r),
    .en      (en),
    .code_in (code_in),
    .clr_err (clr_err),
    .idx     (idx_e2),
    .idx_vld (vld_e2),
    .legal   (legal_e2),
    .locked  (locked_e2),
    .seq_err (seq_err_e2),
    .err_cnt (err_cnt_e2)
  );

  johnson_decoder #(.LOCK_CNT(1), .ERR_W(8)) u_dut_l1 (
    .clk     (clk),
    .r       (r),
    .en      (en),
    .code_in (code_in),
    .clr_err (clr_err),
    .idx     (idx_l1),
    .idx_vld (vld_l1),
    .legal   (legal_l1),
    .locked  (locked_l1),
    .seq_err (seq_err_l1),
    .err_cnt (err_cnt_l1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Johnson state n: n<=8 -> leading n ones; n>8 -> leading (n-8) zeros then ones.
  function automatic logic [0:7] jcode(input int n);
    logic [0:7] c;
    for (int i = 0; i < 8; i++) begin
      c[i] = (n <= 8) ? (i < n) : (i >= n - 8);
    end
    return c;
  endfunction

  task automatic sample(input logic [0:7] c);
    en      = 1'b1;
    code_in = c;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_idx"}, 32'(idx), 32'd0);
    check({tag, "_vld"}, 32'(idx_vld), 32'd0);
    check({tag, "_legal"}, 32'(legal), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_l1_locked"}, 32'(locked_l1), 32'd0);
  endtask

  task automatic async_reset_pulse();
    #2 r = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1 r = 1'b0;
  endtask

  logic [0:7] jc;

  initial begin
    n_total = 0;
    n_pass  = 0;
    r       = 1'b1;
    en      = 1'b0;
    code_in = 8'b0;
    clr_err = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    r = 1'b0;

    // Decode table
    sample(8'b00000000);
    check("dec0_idx", 32'(idx), 32'd0);
    check("dec0_legal", 32'(legal), 32'd1);
    check("dec0_vld", 32'(idx_vld), 32'd1);
    check("dec0_locked", 32'(locked), 32'd0);
    check("l1_first_legal_locked", 32'(locked_l1), 32'd1);
    sample(8'b11111111);
    check("dec8_idx", 32'(idx), 32'd8);
    check("dec8_legal", 32'(legal), 32'd1);
    sample(8'b01111111);
    check("dec9_idx", 32'(idx), 32'd9);
    check("dec9_legal", 32'(legal), 32'd1);
    sample(8'b00000001);
    check("dec15_idx", 32'(idx), 32'd15);
    check("dec15_legal", 32'(legal), 32'd1);

    async_reset_pulse();

    // Free-running Johnson counter, en=1 continuously
    jc = 8'b0;
    for (int k = 0; k < 40; k++) begin
      sample(jc);
      check("run_idx", 32'(idx), 32'(k % 16));
      check("run_locked", 32'(locked), (k >= 1) ? 32'd1 : 32'd0);
      check("run_seq_err", 32'(seq_err), 32'd0);
      jc = {~jc[7], jc[0:6]};
    end
    check("run_err_cnt", 32'(err_cnt), 32'd0);

    // Illegal code while locked
    sample(8'b10100000);
    check("ill_legal", 32'(legal), 32'd0);
    check("ill_idx", 32'(idx), 32'd0);
    check("ill_seq_err", 32'(seq_err), 32'd1);
    check("ill_err_cnt", 32'(err_cnt), 32'd1);
    check("ill_locked", 32'(locked), 32'd0);
    sample(8'b11110000);
    check("relock4_locked", 32'(locked), 32'd0);
    check("relock4_seq_err", 32'(seq_err), 32'd0);
    sample(8'b11111000);
    check("relock5_locked", 32'(locked), 32'd1);

    // Repeated code while locked
    sample(8'b11111000);
    check("rep5_seq_err", 32'(seq_err), 32'd1);
    check("rep5_locked", 32'(locked), 32'd0);
    check("rep5_err_cnt", 32'(err_cnt), 32'd2);
    sample(8'b11111100);
    check("rep6_locked", 32'(locked), 32'd1);
    check("rep6_seq_err", 32'(seq_err), 32'd0);
    sample(8'b11111110);
    check("rep7_locked", 32'(locked), 32'd1);
    check("rep7_idx", 32'(idx), 32'd7);

    // en=0 holds state and suppresses pulses
    en      = 1'b0;
    code_in = 8'b10100000;
    tick();
    check("hold_vld", 32'(idx_vld), 32'd0);
    check("hold_idx", 32'(idx), 32'd7);
    check("hold_legal", 32'(legal), 32'd1);
    check("hold_locked", 32'(locked), 32'd1);
    check("hold_seq_err", 32'(seq_err), 32'd0);
    check("hold_err_cnt", 32'(err_cnt), 32'd2);

    // Error counter saturation on the ERR_W=2 instance
    async_reset_pulse();
    sample(jcode(0));
    sample(jcode(1));
    check("sat_pre_locked", 32'(locked), 32'd1);
    for (int j = 1; j <= 5; j++) begin
      sample(jcode(j));
      check("sat_seq_err", 32'(seq_err_e2), 32'd1);
      check("sat_err_cnt_e2", 32'(err_cnt_e2), (j < 3) ? 32'(j) : 32'd3);
      check("sat_err_cnt", 32'(err_cnt), 32'(j));
      sample(jcode(j + 1));
      check("sat_relock", 32'(locked_e2), 32'd1);
    end
    clr_err = 1'b1;
    sample(jcode(6));
    clr_err = 1'b0;
    check("clr_seq_err", 32'(seq_err), 32'd1);
    check("clr_err_cnt_e2", 32'(err_cnt_e2), 32'd0);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Reset mid-lock, then en toggling, then relock
    sample(jcode(7));
    check("mid_locked", 32'(locked), 32'd1);
    async_reset_pulse();
    en      = 1'b0;
    code_in = jcode(8);
    tick();
    check("post_rst_en0_vld", 32'(idx_vld), 32'd0);
    check("post_rst_en0_locked", 32'(locked), 32'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("post_rst_s8_idx", 32'(idx), 32'd8);
    check("post_rst_s8_locked", 32'(locked), 32'd0);
    check("post_rst_s8_l1_locked", 32'(locked_l1), 32'd1);
    tick();
    check("post_rst_gap_vld", 32'(idx_vld), 32'd0);
    check("post_rst_gap_idx", 32'(idx), 32'd8);
    sample(jcode(9));
    check("post_rst_s9_locked", 32'(locked), 32'd1);
    check("post_rst_s9_idx", 32'(idx), 32'd9);
    check("post_rst_s9_seq_err", 32'(seq_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
